forth_alu_sequencer: RTL
========================

Name: forth_alu_sequencer

Overview:
- Executes one Forth stack primitive per accepted opcode against the data stack.
- Pops operands, computes, pushes results, then reports completion or error.
- Sits directly upstream of the data stack. It is the only master of the stack push/pop strobes in the execute path.
- The instruction decoder feeds it over a valid/ready opcode handshake.

Parameters:
- DATA_WIDTH, 16, width of stack words, literals and ALU datapath.
- DEPTH_WIDTH, 11, width of the stack_depth input. Must represent 0..STACK_DEPTH.
- STACK_DEPTH, 1024, stack capacity in words. Used for overflow pre-check.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- op_valid  input  1  opcode/literal present.
- op_ready  output  1  block idle and able to accept.
- opcode  input  4  primitive select (encoding below).
- literal  input  DATA_WIDTH  value for LIT. Ignored for other opcodes.
- done  output  1  one-cycle pulse when an operation finishes (success or error).
- err  output  2  valid while done=1: 00 ok, 01 underflow, 10 overflow, 11 illegal opcode.
- stack_push  output  1  one-cycle push strobe to the data stack.
- stack_wdata  output  DATA_WIDTH  push data, valid with stack_push.
- stack_pop  output  1  one-cycle pop strobe to the data stack.
- stack_rdata  input  DATA_WIDTH  popped word, valid the cycle after stack_pop.
- stack_depth  input  DEPTH_WIDTH  current stack occupancy.

Behaviour:
- Opcodes:
  - 0 LIT: push literal.
  - 1 ADD: N+T.
  - 2 SUB: N-T.
  - 3 AND, 4 OR, 5 XOR: bitwise N op T.
  - 6 NEG: 0-T.
  - 7 DUP: push T, then T.
  - 8 DROP: pop only.
  - 9 SWAP: push T, then N.
  - 10-15: illegal.
- T is the first word popped (top), N the second.
- Arithmetic is modulo 2^DATA_WIDTH. Carries are discarded and no flags are produced.
- Pops/pushes per opcode:
  - LIT 0/1; ADD..XOR 2/1; NEG 1/1; DUP 1/2; DROP 1/0; SWAP 2/2.
- Reset values:
  - State IDLE.
  - op_ready=0, done=0, err=00, stack_push=0, stack_pop=0, stack_wdata=0.
  - Internal T/N/literal registers cleared.
- op_ready is registered. It goes 1 on the first rising edge after reset deasserts, and is 1 only in IDLE.
- The handshake fires on an edge where op_valid=1 and op_ready=1. The block latches opcode and literal, and op_ready drops on that edge.
- States: IDLE, CHECK, POP1, CAP1, POP2, CAP2, EXEC, PUSH1, PUSH2, DONE.
- CHECK (first cycle after accept): checks are evaluated in this priority order.
  - Illegal opcode -> DONE with err=11.
  - stack_depth < pops required -> DONE with err=01.
  - Net growth >0 (LIT, DUP) and stack_depth == STACK_DEPTH -> DONE with err=10.
  - On any error, no stack strobe is ever issued for that operation.
  - Otherwise go to POP1 if pops ≥1, else EXEC.
- POP1 asserts stack_pop. CAP1 captures stack_rdata into T.
- POP2/CAP2 do the same into N, only for 2-pop opcodes.
- EXEC registers the result(s).
- PUSH1 and PUSH2 each assert stack_push for exactly one cycle with stack_wdata. Skipped states are bypassed in order.
- DROP goes CAP1 -> DONE.
- DONE asserts done=1 for one cycle, then returns to IDLE (op_ready=1 next cycle).
- stack_push and stack_pop are never asserted in the same cycle, and never outside POPx/PUSHx.
- stack_wdata holds its last value when stack_push=0.
- Latency, accept edge to done pulse:
  - ADD: 7 cycles (CHECK, POP1, CAP1, POP2, CAP2, EXEC, PUSH1, then DONE on 8th).
  - LIT: CHECK, EXEC, PUSH1, DONE.
  - Error: CHECK, DONE.
- op_valid while busy is ignored; the decoder holds it until op_ready.
- stack_depth is sampled only in CHECK. Changes later in the operation do not matter.
- Reset mid-operation: immediate return to reset values. Partially popped operands are lost and no further strobes occur. Stack consistency is the stack's own reset's responsibility.

Test Plan:
- Reset low 3 cycles then high; LIT 0x1234 at depth 0 -> op_ready=1 one edge after release; exactly one stack_push with wdata=0x1234; done with err=00 four cycles after accept.
- Depth 2, stack holds N=0x0005 then T=0x0003:
  - SUB -> two pops, one push of 0x0002, err=00.
  - Repeat with N=0x0003, T=0x0005 -> push 0xFFFE.
- SWAP with T=0xAAAA, N=0x5555 -> pushes 0xAAAA then 0x5555; DUP with T=0x00FF -> two pushes of 0x00FF.
- ADD at depth 1 -> done, err=01, zero stack_pop/stack_push pulses. DUP at depth 1024 -> err=10, no strobes. Opcode 12 -> err=11, no strobes.
- Back-to-back: op_valid held high with LIT 1, then LIT 2, then ADD -> each accepted only when op_ready=1; final push 0x0003.
- Reset asserted in CAP1 of ADD -> all outputs 0 asynchronously; no push follows; next LIT after release completes normally.

Source files
------------

// File: rtl/forth_alu_sequencer.sv
// -----------------------------------------------------------------------------
// forth_alu_sequencer
//
// Executes one Forth stack primitive per accepted opcode. Each operation pops
// its operands from the data stack, computes in a small ALU, pushes the
// result(s) back, then pulses done with an error code. This block is the only
// driver of the stack push/pop strobes in the execute path.
//
// Ports:
//   clock        single clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   op_valid     opcode/literal present from the decoder
//   op_ready     registered; high only while idle and able to accept
//   opcode       primitive select (0 LIT .. 9 SWAP, 10-15 illegal)
//   literal      value pushed by LIT, ignored otherwise
//   done         one-cycle pulse when an operation finishes
//   err          valid with done: 00 ok, 01 underflow, 10 overflow, 11 illegal
//   stack_push   one-cycle push strobe, stack_wdata valid with it
//   stack_wdata  push data, holds its last value between pushes
//   stack_pop    one-cycle pop strobe
//   stack_rdata  popped word, valid the cycle after stack_pop
//   stack_depth  current stack occupancy, sampled only in CHECK
// -----------------------------------------------------------------------------
module forth_alu_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11,
    parameter int STACK_DEPTH = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [3:0]             opcode,
    input  logic [DATA_WIDTH-1:0]  literal,
    output logic                   done,
    output logic [1:0]             err,
    output logic                   stack_push,
    output logic [DATA_WIDTH-1:0]  stack_wdata,
    output logic                   stack_pop,
    input  logic [DATA_WIDTH-1:0]  stack_rdata,
    input  logic [DEPTH_WIDTH-1:0] stack_depth
);

    localparam logic [3:0] OP_LIT  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NEG  = 4'd6;
    localparam logic [3:0] OP_DUP  = 4'd7;
    localparam logic [3:0] OP_DROP = 4'd8;
    localparam logic [3:0] OP_SWAP = 4'd9;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_POP1,
        S_CAP1,
        S_POP2,
        S_CAP2,
        S_EXEC,
        S_PUSH1,
        S_PUSH2,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    op_ready_q, op_ready_d;
    logic [3:0]              opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   lit_q, lit_d;
    logic [DATA_WIDTH-1:0]   t_q, t_d;
    logic [DATA_WIDTH-1:0]   n_q, n_d;
    logic [DATA_WIDTH-1:0]   res2_q, res2_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]              err_q, err_d;

    // Opcode decode: operand/result counts and legality.
    logic       op_legal;
    logic [1:0] pops_req;
    logic [1:0] pushes_req;
    logic       grows;
    logic       stack_full;

    // ALU results for the first and (DUP/SWAP only) second push.
    logic [DATA_WIDTH-1:0] res1;
    logic [DATA_WIDTH-1:0] res2;

    // NOTE: every signal driven in an always_comb gets a default assignment
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        op_legal   = 1'b1;
        pops_req   = 2'd0;
        pushes_req = 2'd0;
        case (opcode_q)
            OP_LIT:                         begin pops_req = 2'd0; pushes_req = 2'd1; end
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR:                  begin pops_req = 2'd2; pushes_req = 2'd1; end
            OP_NEG:                         begin pops_req = 2'd1; pushes_req = 2'd1; end
            OP_DUP:                         begin pops_req = 2'd1; pushes_req = 2'd2; end
            OP_DROP:                        begin pops_req = 2'd1; pushes_req = 2'd0; end
            OP_SWAP:                        begin pops_req = 2'd2; pushes_req = 2'd2; end
            default:                        op_legal = 1'b0;
        endcase
    end

    assign grows      = (pushes_req > pops_req);
    assign stack_full = (stack_depth == DEPTH_WIDTH'(STACK_DEPTH));

    // T is the first word popped (top of stack), N the second.
    always_comb begin
        res1 = t_q;
        res2 = t_q;
        case (opcode_q)
            OP_LIT:  res1 = lit_q;
            OP_ADD:  res1 = n_q + t_q;
            OP_SUB:  res1 = n_q - t_q;
            OP_AND:  res1 = n_q & t_q;
            OP_OR:   res1 = n_q | t_q;
            OP_XOR:  res1 = n_q ^ t_q;
            OP_NEG:  res1 = '0 - t_q;
            OP_SWAP: res2 = n_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        lit_d    = lit_q;
        t_d      = t_q;
        n_d      = n_q;
        res2_d   = res2_q;
        wdata_d  = wdata_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready_q) begin
                    opcode_d = opcode;
                    lit_d    = literal;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                // Priority: illegal, underflow, overflow. Errors skip every
                // stack state so no strobe is issued for a failed operation.
                err_d = ERR_OK;
                if (!op_legal) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = S_DONE;
                end else if (stack_depth < DEPTH_WIDTH'(pops_req)) begin
                    err_d   = ERR_UNDERFLOW;
                    state_d = S_DONE;
                end else if (grows && stack_full) begin
                    err_d   = ERR_OVERFLOW;
                    state_d = S_DONE;
                end else if (pops_req != 2'd0) begin
                    state_d = S_POP1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_POP1: state_d = S_CAP1;
            S_CAP1: begin
                t_d = stack_rdata;
                if (pushes_req == 2'd0) begin
                    state_d = S_DONE;
                end else if (pops_req == 2'd2) begin
                    state_d = S_POP2;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_POP2: state_d = S_CAP2;
            S_CAP2: begin
                n_d     = stack_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Push data is loaded on entry to a PUSH state so it is
                // stable for the whole strobe and held afterwards.
                wdata_d = res1;
                res2_d  = res2;
                state_d = S_PUSH1;
            end
            S_PUSH1: begin
                if (pushes_req == 2'd2) begin
                    wdata_d = res2_q;
                    state_d = S_PUSH2;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PUSH2: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        op_ready_d = (state_d == S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_ready_q <= 1'b0;
            opcode_q   <= '0;
            lit_q      <= '0;
            t_q        <= '0;
            n_q        <= '0;
            res2_q     <= '0;
            wdata_q    <= '0;
            err_q      <= ERR_OK;
        end else begin
            state_q    <= state_d;
            op_ready_q <= op_ready_d;
            opcode_q   <= opcode_d;
            lit_q      <= lit_d;
            t_q        <= t_d;
            n_q        <= n_d;
            res2_q     <= res2_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    // Strobes decode straight from the registered state, so they drop
    // asynchronously with reset and can never overlap.
    assign op_ready    = op_ready_q;
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign stack_pop   = (state_q == S_POP1) || (state_q == S_POP2);
    assign stack_push  = (state_q == S_PUSH1) || (state_q == S_PUSH2);
    assign stack_wdata = wdata_q;

endmodule
